// File: rtl/zstr_fifo_sync_if.sv
// Handshake bundle for zstr_fifo_sync: write side (zi_*) and read side (zo_*).
// The slave modport is the FIFO's view; master is the surrounding logic's view.
interface zstr_fifo_sync_if #(
  parameter int BW = 8,
  parameter int LN = 5
);
  localparam int CNL = $clog2(LN + 1);

  logic           zi_vld;
  logic [BW-1:0]  zi_bus;
  logic           zi_ack;
  logic [CNL-1:0] zi_num;
  logic           zi_afl;

  logic           zo_vld;
  logic [BW-1:0]  zo_bus;
  logic           zo_ack;
  logic [CNL-1:0] zo_num;
  logic           zo_ael;

  modport master (
    output zi_vld, zi_bus, zo_ack,
    input  zi_ack, zi_num, zi_afl, zo_vld, zo_bus, zo_num, zo_ael
  );

  modport slave (
    input  zi_vld, zi_bus, zo_ack,
    output zi_ack, zi_num, zi_afl, zo_vld, zo_bus, zo_num, zo_ael
  );
endinterface

// File: rtl/zstr_fifo_sync.sv
// Synchronous fall-through FIFO, any depth LN >= 1, one-cycle write-to-read latency.
// Optional synchronous flush input enabled by defining ZSTR_FIFO_FLUSH_EN.
module zstr_fifo_sync #(
  parameter int BW  = 8,
  parameter int LN  = 5,
  parameter int AFN = 1,
  parameter int AEN = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef ZSTR_FIFO_FLUSH_EN
  input  logic flush,
`endif
  zstr_fifo_sync_if.slave z
);

  localparam int LNL = (LN > 1) ? $clog2(LN) : 1;
  localparam int CNL = $clog2(LN + 1);

  localparam logic [CNL-1:0] CNT_FULL = CNL'(LN);
  localparam logic [LNL-1:0] PTR_LAST = LNL'(LN - 1);

  logic [CNL-1:0] cnt_q, cnt_d;
  logic [LNL-1:0] wpb_q, wpb_d;
  logic [LNL-1:0] rpb_q, rpb_d;

  logic [BW-1:0]  mem [LN];

  logic           zi_ack;
  logic           zo_vld;
  logic           zi_trn;
  logic           zo_trn;
  logic [CNL-1:0] zi_num;

  function automatic logic [LNL-1:0] ptr_inc(input logic [LNL-1:0] p);
    return (p == PTR_LAST) ? '0 : p + LNL'(1);
  endfunction

  // Handshake flags depend only on registered occupancy (and flush), never on the far side's strobe.
`ifdef ZSTR_FIFO_FLUSH_EN
  assign zi_ack = (cnt_q != CNT_FULL) & ~flush;
  assign zo_vld = (cnt_q != '0) & ~flush;
`else
  assign zi_ack = (cnt_q != CNT_FULL);
  assign zo_vld = (cnt_q != '0);
`endif

  assign zi_trn = z.zi_vld & zi_ack;
  assign zo_trn = zo_vld & z.zo_ack;
  assign zi_num = CNT_FULL - cnt_q;

  assign z.zi_ack = zi_ack;
  assign z.zo_vld = zo_vld;
  assign z.zi_num = zi_num;
  assign z.zo_num = cnt_q;
  assign z.zi_afl = int'(zi_num) <= AFN;
  assign z.zo_ael = int'(cnt_q) <= AEN;
  assign z.zo_bus = mem[rpb_q];

  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    wpb_d = wpb_q;
    rpb_d = rpb_q;
    if (zi_trn && !zo_trn) begin
      cnt_d = cnt_q + CNL'(1);
    end else if (zo_trn && !zi_trn) begin
      cnt_d = cnt_q - CNL'(1);
    end
    if (zi_trn) begin
      wpb_d = ptr_inc(wpb_q);
    end
    if (zo_trn) begin
      rpb_d = ptr_inc(rpb_q);
    end
`ifdef ZSTR_FIFO_FLUSH_EN
    if (flush) begin
      cnt_d = '0;
      wpb_d = '0;
      rpb_d = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      wpb_q <= '0;
      rpb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wpb_q <= wpb_d;
      rpb_q <= rpb_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates its visibility. Writes are suppressed under reset.
  always_ff @(posedge clk) begin
    if (zi_trn && !rst) begin
      mem[wpb_q] <= z.zi_bus;
    end
  end

endmodule

// File: doc/zstr_fifo_sync.md
ZSTR_FIFO_SYNC -- requirements
Module: zstr_fifo_sync

Interface
REQ-001 SHALL have parameter BW, default 8: bus width in bits, minimum 1.
REQ-002 SHALL have parameter LN, default 5: depth in locations, any integer >= 1, not restricted to powers of two.
REQ-003 SHALL have parameter AFN, default 1: almost-full threshold on zi_num.
REQ-004 SHALL have parameter AEN, default 1: almost-empty threshold on zo_num.
REQ-005 SHALL derive localparams LNL = max(1, $clog2(LN)) and CNL = $clog2(LN+1).
REQ-006 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-008 SHALL have port zi_vld, input, 1 bit: write transfer valid.
REQ-009 SHALL have port zi_bus, input, BW bits: write data.
REQ-010 SHALL have port zi_ack, output, 1 bit: write acknowledge, meaning space is available.
REQ-011 SHALL have port zi_num, output, CNL bits: number of empty locations.
REQ-012 SHALL have port zi_afl, output, 1 bit: almost full.
REQ-013 SHALL have port zo_vld, output, 1 bit: read data valid.
REQ-014 SHALL have port zo_bus, output, BW bits: read data.
REQ-015 SHALL have port zo_ack, input, 1 bit: read acknowledge.
REQ-016 SHALL have port zo_num, output, CNL bits: number of loaded locations.
REQ-017 SHALL have port zo_ael, output, 1 bit: almost empty.
REQ-018 SHALL have port flush, input, 1 bit, present only when ZSTR_FIFO_FLUSH_EN is defined.

Function
REQ-019 SHALL define transfers zi_trn = zi_vld & zi_ack and zo_trn = zo_vld & zo_ack; a transfer completes on the clk edge where it is high.
REQ-020 SHALL keep registered occupancy cnt (CNL bits), updated each edge as cnt + zi_trn - zo_trn.
REQ-021 SHALL drive zo_num = cnt and zi_num = LN - cnt, both combinational from registers.
REQ-022 SHALL drive zi_ack = (cnt != LN) and zo_vld = (cnt != 0), with no combinational path from zo_ack to zi_ack or from zi_vld to zo_vld.
REQ-023 SHALL drive zi_afl = (zi_num <= AFN) and zo_ael = (zo_num <= AEN).
REQ-024 SHALL write zi_bus to mem[wpb] on zi_trn; wpb increments and wraps from LN-1 to 0.
REQ-025 SHALL present zo_bus = mem[rpb] in fall-through mode; rpb increments on zo_trn and wraps from LN-1 to 0.
REQ-026 SHALL set write-to-read latency to 1 cycle: data written at edge N is visible with zo_vld=1 after edge N; no same-cycle bypass when empty.
REQ-027 SHALL, on simultaneous zi_trn and zo_trn, leave cnt unchanged and advance both pointers; this also holds at the LN-1 wrap of each pointer.
REQ-028 SHALL, when full, refuse writes (zi_ack=0) even if zo_ack=1 in the same cycle; the freed slot is acknowledged the next cycle.
REQ-029 SHALL hold zo_bus stable while zo_vld=1 and zo_ack=0.
REQ-030 SHALL, when LN=1, use a single location with pointers fixed at 0 and alternate full and empty.

Reset
REQ-031 SHALL, while rst=1, asynchronously set cnt=0, wpb=0 and rpb=0, giving zi_ack=1, zi_num=LN, zo_vld=0, zo_num=0, zo_ael=1 and zi_afl=(LN<=AFN).
REQ-032 SHALL leave memory contents unreset, and SHALL abort any in-flight transfer on reset assertion mid-operation, with no write committed.

Configuration
REQ-033 SHALL, with macro ZSTR_FIFO_FLUSH_EN defined, provide input flush: when flush=1 at an edge, cnt, wpb and rpb become 0 at that edge, zi_ack and zo_vld are forced to 0 during the flush cycle, and no transfer occurs in that cycle.
REQ-034 SHALL, without ZSTR_FIFO_FLUSH_EN, have no flush port and no flush logic.

Verification (BW=8, LN=5, AFN=1, AEN=1)
REQ-035 SHALL cover fill to full: after reset, 5 writes 0x11..0x55 with zo_ack=0 -> zi_num 5->0, zi_ack=0, zi_afl=1 when zi_num<=1, a 6th write is not acknowledged, zo_num=5.
REQ-036 SHALL cover drain in order: from full, zo_ack=1 for 5 cycles -> zo_bus 0x11,0x22,0x33,0x44,0x55, then zo_vld=0, zo_ael=1, zi_num=5.
REQ-037 SHALL cover streaming across wrap: 20 cycles of zi_vld=1 and zo_ack=1 with cnt=2 -> cnt stays 2, data in order, both pointers wrap 4->0 without loss.
REQ-038 SHALL cover full plus simultaneous read: cnt=5, zi_vld=1, zo_ack=1 -> one read, no write that cycle, write accepted next cycle, cnt 5->4->5.
REQ-039 SHALL cover reset mid-stream: rst asserted with cnt=3 -> zo_vld=0, zi_num=5 immediately (asynchronous), first post-reset write reads back correctly.
REQ-040 SHALL cover flush (ZSTR_FIFO_FLUSH_EN defined): flush=1 with cnt=4 and zi_vld=1 -> no ack that cycle, cnt=0 next cycle, zo_vld=0.
